pipeline_hazard_ctrl: RTL and testbench

//  Stall/flush sequencer for the 5-stage pipeline. Observes ID, EX and MEM stage fields.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 13 +
 rtl/pipeline_hazard_ctrl_sat_counter.sv | 19 +
 rtl/pipeline_hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: FSM state encoding
// and the hard-wired zero register number.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_STALL  = 2'd1,
        ST_DMWAIT = 2'd2
    } state_t;

    localparam logic [4:0] REG0 = 5'd0;

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Up-counter with asynchronous active-low clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use and branch-ALU interlocks,
// taken-branch/jump flushes, data-memory wait, plus stall/flush event counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int BR_LU_STALL = 2,
    parameter int CNT_W       = 16
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic [4:0]       IDrs,
    input  logic [4:0]       IDrt,
    input  logic             IDusesRt,
    input  logic             IDBranch,
    input  logic             IDJump,
    input  logic             EXmemread,
    input  logic             EXregwrite,
    input  logic [4:0]       EXDest,
    input  logic             BranchTaken,
    input  logic             DMemBusy,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             EXMEMWrite,
    output logic             MEMWBWrite,
    output logic             IFIDFlush,
    output logic             IDEXFlush,
    output logic             EXMEMFlush,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushEvents
);

    localparam logic [1:0] BR_REMAIN = 2'(BR_LU_STALL - 1);

    state_t     state, state_nxt, saved_state, saved_state_nxt;
    logic [1:0] remain, remain_nxt, saved_remain, saved_remain_nxt;
    state_t     eff_state;
    logic [1:0] eff_remain;
    logic       lu, ba;

    assign lu = EXmemread && (EXDest != REG0) &&
                ((EXDest == IDrs) || (IDusesRt && (EXDest == IDrt)));
    assign ba = IDBranch && EXregwrite && !EXmemread && (EXDest != REG0) &&
                ((EXDest == IDrs) || (EXDest == IDrt));

    // The first not-busy cycle after a memory wait behaves as the state that was interrupted.
    assign eff_state  = (state == ST_DMWAIT) ? saved_state  : state;
    assign eff_remain = (state == ST_DMWAIT) ? saved_remain : remain;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= ST_RUN;
            remain       <= 2'd0;
            saved_state  <= ST_RUN;
            saved_remain <= 2'd0;
        end else begin
            state        <= state_nxt;
            remain       <= remain_nxt;
            saved_state  <= saved_state_nxt;
            saved_remain <= saved_remain_nxt;
        end
    end

    always_comb begin
        state_nxt        = ST_RUN;
        remain_nxt       = 2'd0;
        saved_state_nxt  = saved_state;
        saved_remain_nxt = saved_remain;
        if (BranchTaken) begin
            state_nxt  = ST_RUN;
            remain_nxt = 2'd0;
        end else if (DMemBusy) begin
            state_nxt  = ST_DMWAIT;
            remain_nxt = remain;
            if (state != ST_DMWAIT) begin
                saved_state_nxt  = state;
                saved_remain_nxt = remain;
            end
        end else if (eff_state == ST_STALL) begin
            state_nxt  = (eff_remain == 2'd1) ? ST_RUN : ST_STALL;
            remain_nxt = eff_remain - 2'd1;
        end else if (lu && IDBranch && (BR_LU_STALL > 1)) begin
            state_nxt  = ST_STALL;
            remain_nxt = BR_REMAIN;
        end
    end

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IDEXWrite  = 1'b1;
        EXMEMWrite = 1'b1;
        MEMWBWrite = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXFlush  = 1'b0;
        EXMEMFlush = 1'b0;
        if (!Reset_n) begin
            {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite} = 5'b00000;
            {IFIDFlush, IDEXFlush, EXMEMFlush}                       = 3'b111;
        end else if (BranchTaken) begin
            {IFIDFlush, IDEXFlush, EXMEMFlush} = 3'b111;
        end else if (DMemBusy) begin
            {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite} = 5'b00000;
        end else if ((eff_state == ST_STALL) || lu || ba) begin
            PCWrite   = 1'b0;
            IFIDWrite = 1'b0;
            IDEXFlush = 1'b1;
        end else if (IDJump) begin
            IFIDFlush = 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (Clk),
        .rst_n (Reset_n),
        .inc   (!PCWrite),
        .cnt   (StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (Clk),
        .rst_n (Reset_n),
        .inc   (IFIDFlush || IDEXFlush || EXMEMFlush),
        .cnt   (FlushEvents)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; a second instance with 2-bit counters
// shares the stimulus so counter saturation is reached quickly.
module tb_pipeline_hazard_ctrl;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [4:0]  IDrs, IDrt, EXDest;
    logic        IDusesRt, IDBranch, IDJump, EXmemread, EXregwrite, BranchTaken, DMemBusy;
    logic        PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite;
    logic        IFIDFlush, IDEXFlush, EXMEMFlush;
    logic [15:0] StallCycles, FlushEvents;
    logic        s_pc, s_ifid, s_idex, s_exmem, s_memwb, s_fifid, s_fidex, s_fexmem;
    logic [1:0]  s_stall, s_flush;

    int total = 0;
    int bad   = 0;

    localparam logic [7:0] DEF = 8'b11111_000;
    localparam logic [7:0] STL = 8'b00111_010;
    localparam logic [7:0] BRF = 8'b11111_111;
    localparam logic [7:0] BSY = 8'b00000_000;
    localparam logic [7:0] JMP = 8'b11111_100;
    localparam logic [7:0] RST = 8'b00000_111;

    always #5 Clk = ~Clk;

    pipeline_hazard_ctrl #(.BR_LU_STALL(2), .CNT_W(16)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .IDrs(IDrs), .IDrt(IDrt), .IDusesRt(IDusesRt),
        .IDBranch(IDBranch), .IDJump(IDJump), .EXmemread(EXmemread), .EXregwrite(EXregwrite),
        .EXDest(EXDest), .BranchTaken(BranchTaken), .DMemBusy(DMemBusy),
        .PCWrite(PCWrite), .IFIDWrite(IFIDWrite), .IDEXWrite(IDEXWrite),
        .EXMEMWrite(EXMEMWrite), .MEMWBWrite(MEMWBWrite), .IFIDFlush(IFIDFlush),
        .IDEXFlush(IDEXFlush), .EXMEMFlush(EXMEMFlush),
        .StallCycles(StallCycles), .FlushEvents(FlushEvents)
    );

    pipeline_hazard_ctrl #(.BR_LU_STALL(2), .CNT_W(2)) dut_sat (
        .Clk(Clk), .Reset_n(Reset_n), .IDrs(IDrs), .IDrt(IDrt), .IDusesRt(IDusesRt),
        .IDBranch(IDBranch), .IDJump(IDJump), .EXmemread(EXmemread), .EXregwrite(EXregwrite),
        .EXDest(EXDest), .BranchTaken(BranchTaken), .DMemBusy(DMemBusy),
        .PCWrite(s_pc), .IFIDWrite(s_ifid), .IDEXWrite(s_idex),
        .EXMEMWrite(s_exmem), .MEMWBWrite(s_memwb), .IFIDFlush(s_fifid),
        .IDEXFlush(s_fidex), .EXMEMFlush(s_fexmem),
        .StallCycles(s_stall), .FlushEvents(s_flush)
    );

    wire [7:0] outs = {PCWrite, IFIDWrite, IDEXWrite, EXMEMWrite, MEMWBWrite,
                       IFIDFlush, IDEXFlush, EXMEMFlush};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic neutral();
        IDrs = 5'd0; IDrt = 5'd0; EXDest = 5'd0;
        IDusesRt = 1'b0; IDBranch = 1'b0; IDJump = 1'b0;
        EXmemread = 1'b0; EXregwrite = 1'b0; BranchTaken = 1'b0; DMemBusy = 1'b0;
    endtask

    task automatic lu_branch();
        neutral();
        EXmemread = 1'b1; EXDest = 5'd7; IDrt = 5'd7; IDusesRt = 1'b1; IDBranch = 1'b1;
    endtask

    // Inputs are already set; check combinational outputs mid-cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [7:0] exp);
        #2;
        chk(tag, {24'd0, outs}, {24'd0, exp});
        @(posedge Clk);
        #1;
    endtask

    task automatic cnts(input string tag, input int s, input int f);
        chk({tag, "_stall"}, {16'd0, StallCycles}, s);
        chk({tag, "_flush"}, {16'd0, FlushEvents}, f);
    endtask

    initial begin
        neutral();
        Reset_n = 1'b0;
        #1;
        chk("reset_outs", {24'd0, outs}, {24'd0, RST});
        cnts("reset", 0, 0);
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;

        neutral();                                   cyc("idle", DEF);
        cnts("idle", 0, 0);

        // Load-use on rs: one bubble, then the dependent add proceeds
        EXmemread = 1'b1; EXDest = 5'd7; IDrs = 5'd7; cyc("lu_rs", STL);
        neutral(); IDrs = 5'd7;                      cyc("lu_after", DEF);
        cnts("lu", 1, 1);

        // Load to $0 never interlocks
        EXmemread = 1'b1; EXDest = 5'd0; IDrs = 5'd0; cyc("lu_reg0", DEF);

        // Branch waiting on an ALU result one stage ahead
        neutral(); EXregwrite = 1'b1; EXDest = 5'd5; IDrt = 5'd5; IDBranch = 1'b1;
        cyc("ba", STL);
        neutral(); IDBranch = 1'b1;                  cyc("ba_after", DEF);

        // rt only matters when the ID instruction reads it
        neutral(); EXmemread = 1'b1; EXDest = 5'd9; IDrt = 5'd9; IDrs = 5'd1;
        cyc("lu_rt_unused", DEF);
        IDusesRt = 1'b1;                             cyc("lu_rt_used", STL);
        cnts("ba_lu", 3, 3);
        chk("sat_stall_3", {30'd0, s_stall}, 32'd3);

        // Branch on a load result: two stall cycles; a jump in the second is ignored
        lu_branch();                                 cyc("brlu_1", STL);
        neutral(); IDJump = 1'b1;                    cyc("brlu_2", STL);
        neutral(); IDJump = 1'b1;                    cyc("jump", JMP);
        cnts("brlu", 5, 6);
        chk("sat_stall_hold", {30'd0, s_stall}, 32'd3);
        chk("sat_flush_hold", {30'd0, s_flush}, 32'd3);

        // Taken branch during STALL wins and returns to RUN
        lu_branch();                                 cyc("br_stall_enter", STL);
        BranchTaken = 1'b1;                          cyc("br_in_stall", BRF);
        neutral();                                   cyc("br_run", DEF);
        cnts("br", 6, 8);

        // Memory wait in STALL with Remain=1 resumes that last stall cycle
        lu_branch();                                 cyc("dm_enter", STL);
        DMemBusy = 1'b1;                             cyc("dm_busy1", BSY);
                                                     cyc("dm_busy2", BSY);
                                                     cyc("dm_busy3", BSY);
        neutral();                                   cyc("dm_resume", STL);
                                                     cyc("dm_run", DEF);
        cnts("dm", 11, 10);

        // Taken branch overrides a busy data memory
        DMemBusy = 1'b1; BranchTaken = 1'b1;         cyc("br_over_busy", BRF);
        neutral();                                   cyc("br_over_after", DEF);
        cnts("brbusy", 11, 11);

        // Reset in the middle of a branch stall leaves no residue
        lu_branch();                                 cyc("rst_stall", STL);
        Reset_n = 1'b0;
        #1;
        chk("rst_mid_outs", {24'd0, outs}, {24'd0, RST});
        cnts("rst_mid", 0, 0);
        @(posedge Clk);
        #1;
        chk("rst_hold_outs", {24'd0, outs}, {24'd0, RST});
        Reset_n = 1'b1;
        neutral();                                   cyc("rst_release", DEF);
        cnts("rst_release", 0, 0);
        chk("sat_after_rst", {30'd0, s_stall}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
